timer_scheduler: RTL and testbench
==================================

Name: timer_scheduler

Overview:
- Shares one instance of the team's 32-bit upcounter between NUM_REQ requesters that each need a programmable cycle delay.
- Arbitrates round-robin, latches the winner's delay, and sequences the counter's load/start.
- Detects terminal count and returns a one-cycle done pulse to the owning requester.
- Sits between firmware-visible delay/timeout users (e.g. the MLP sequencer and peripheral wait states) and the shared counter.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low. Also drives the internal upcounter's rst_n.
- req_valid_i  in  NUM_REQ  per-requester delay request.
- req_ready_o  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both 1.
- req_delay_i  in  NUM_REQ*32  per-requester delay value; slice i is bits [32*i+31:32*i].
- done_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- busy_o  out  1  high from accept through the done cycle.
- active_id_o  out  ID_W  index of the current or last owner.
- count_o  out  32  mirror of the internal counter value.

Behaviour:
- Reset values:
  - state = IDLE; rr_ptr = 0; load_q = 0; active_id_o = 0.
  - req_ready_o = 0; done_o = 0; busy_o = 0; count_o = 0.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - Round-robin grant: the first requester with valid=1, searching from rr_ptr upward and wrapping.
  - req_ready_o[grant] = 1 combinationally; all other ready bits are 0. No valid request means all ready bits are 0.
  - On transfer: load_q <= delay slice of the winner; active_id <= grant; rr_ptr <= grant+1 mod NUM_REQ; go to START.
- START:
  - Assert counter start for exactly this one cycle; counter load = load_q. Go to RUN.
- RUN:
  - Counter load held at load_q; start = 0.
  - When counter count == load_q, go to DONE. On the same edge the counter self-clears to 0.
- DONE:
  - done_o[active_id] = 1 for this one cycle; go to IDLE.
- Latency: transfer at cycle 0 gives START at cycle 1 and count 0 at cycle 2; done_o is high in cycle 3+D for delay D.
  - D = 0 gives done in cycle 3.
  - D = 0xFFFFFFFF is legal; no timeout is applied.
- busy_o = (state != IDLE).
- req_ready_o is never asserted outside IDLE. Requesters hold valid and delay stable until accepted; a request arriving during RUN waits.
- Back-to-back: the earliest next accept is the cycle after DONE. The counter is guaranteed to be 0 again by then.
- Simultaneous requests are resolved by rr_ptr. Fairness: a continuously-valid requester is served within NUM_REQ grants.
- A requester dropping valid before ready is allowed. It is not latched and no done is issued.
- rst_n low mid-operation: FSM, rr_ptr and counter return to reset values immediately. Pending done is lost and no done pulse is emitted after reset.
- Width: delay and count are 32-bit unsigned with no arithmetic beyond the comparison.

Optional Feature:
- Macro: TIMER_SCHED_STATS_EN.
- Defined: adds output stats_o, NUM_REQ*16 bits. Each slice is a per-requester 16-bit completion counter.
  - Increments in the DONE cycle for active_id.
  - Saturates at 0xFFFF.
  - Reset to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package timer_sched_pkg holds:
  - state typedef {IDLE, START, RUN, DONE} as 2-bit encodings 0..3;
  - the 32-bit delay width constant;
  - the 16-bit stats width constant.
- Sub-modules:
  - the existing upcounter, instantiated once;
  - optionally rr_arbiter, a combinational grant from valid + pointer, parameterised by NUM_REQ.

Test Plan:
- Single request, D=5 on requester 1 at cycle 0 -> ready[1]=1 at cycle 0, start at cycle 1, done_o=4'b0010 only at cycle 8, busy_o high cycles 1-8.
- D=0 on requester 0 -> done_o[0] pulse at cycle 3. Counter is 0 at cycle 4, so an immediate second request D=2 completes 5 cycles after its accept.
- All 4 requesters valid continuously with D=1, rr_ptr=0 -> grant order 0,1,2,3,0, each done 4 cycles after its accept, with no starvation.
- Requester 2 valid during requester 0's RUN with D=10 -> ready[2] stays 0 until the cycle after done_o[0], then is accepted.
- rst_n pulsed low during RUN with count=7 -> count_o=0, busy_o=0, no done_o; after release, a new D=3 request completes normally.
- With TIMER_SCHED_STATS_EN: 3 completions on requester 3 -> stats_o[63:48]=3. Preload to 0xFFFF via repeated runs (or force) -> stays 0xFFFF.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler slice.
//   DELAY_W : width of requester delays and the shared counter value
//   STATS_W : width of each per-requester completion counter
//   state_t : scheduler FSM encoding (IDLE=0, START=1, RUN=2, DONE=3)
package timer_sched_pkg;

  localparam int unsigned DELAY_W = 32;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid_i     : per-requester request bits
//   ptr_i       : highest-priority index (search starts here and wraps)
//   gnt_valid_o : at least one request is present
//   gnt_id_o    : index of the granted requester
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               gnt_valid_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr_i is always < NUM_REQ, so a single conditional subtract wraps.
      w_sum = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!gnt_valid_o && valid_i[w_idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = w_idx;
      end
    end
  end

endmodule

// File: rtl/upcounter.sv
// Shared 32-bit upcounter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : one-cycle pulse, clears the count to 0 and begins counting
//   load_i     : terminal value; on reaching it the count self-clears and stops
//   count_o    : current count value
module upcounter
  import timer_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DELAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] count_o
);

  logic             r_run;
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_count <= '0;
    end else if (start_i) begin
      r_run   <= 1'b1;
      r_count <= '0;
    end else if (r_run) begin
      if (r_count == load_i) begin
        r_run   <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/timer_scheduler.sv
// Timer scheduler: shares one upcounter among NUM_REQ delay requesters.
//   clk, rst_n   : clock, asynchronous active-low reset (also resets the counter)
//   req_valid_i  : per-requester delay request
//   req_ready_o  : per-requester accept (only in IDLE, to the round-robin winner)
//   req_delay_i  : per-requester 32-bit delay, slice i = [32*i+31:32*i]
//   done_o       : one-cycle completion pulse to the owning requester
//   busy_o       : high whenever the scheduler is not IDLE
//   active_id_o  : index of the current or last owner
//   count_o      : mirror of the shared counter
//   stats_o      : per-requester 16-bit saturating completion counts
//                  (present only when TIMER_SCHED_STATS_EN is defined)
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DELAY_W-1:0] req_delay_i,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic [ID_W-1:0]            active_id_o,
  output logic [DELAY_W-1:0]         count_o
`ifdef TIMER_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] stats_o
`endif
);

  state_t               r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_active_id;
  logic [DELAY_W-1:0]   r_load_q;

  logic                 w_gnt_valid;
  logic [ID_W-1:0]      w_gnt_id;
  logic                 w_transfer;
  logic [ID_W-1:0]      w_next_ptr;
  logic [DELAY_W-1:0]   w_count;
  logic [DELAY_W-1:0]   w_delay [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_delay
    assign w_delay[g] = req_delay_i[g*DELAY_W +: DELAY_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (r_rr_ptr),
    .gnt_valid_o (w_gnt_valid),
    .gnt_id_o    (w_gnt_id)
  );

  upcounter #(
    .WIDTH (DELAY_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (r_state == START),
    .load_i  (r_load_q),
    .count_o (w_count)
  );

  assign w_transfer = (r_state == IDLE) && w_gnt_valid;
  assign w_next_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_active_id <= '0;
      r_load_q    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_load_q    <= w_delay[w_gnt_id];
            r_active_id <= w_gnt_id;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= START;
          end
        end
        START: r_state <= RUN;
        RUN: begin
          if (w_count == r_load_q) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    done_o      = '0;
    if (w_transfer) begin
      req_ready_o[w_gnt_id] = 1'b1;
    end
    if (r_state == DONE) begin
      done_o[r_active_id] = 1'b1;
    end
  end

  assign busy_o      = (r_state != IDLE);
  assign active_id_o = r_active_id;
  assign count_o     = w_count;

`ifdef TIMER_SCHED_STATS_EN
  logic [STATS_W-1:0] r_stats [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_stats[i] <= '0;
      end
    end else if (r_state == DONE && r_stats[r_active_id] != '1) begin
      r_stats[r_active_id] <= r_stats[r_active_id] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign stats_o[g*STATS_W +: STATS_W] = r_stats[g];
  end
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;
  import timer_sched_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DELAY_W-1:0] req_delay;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;
  logic [ID_W-1:0]            active_id;
  logic [DELAY_W-1:0]         count;
  logic [31:0]                dly [NUM_REQ];
`ifdef TIMER_SCHED_STATS_EN
  logic [NUM_REQ*STATS_W-1:0] stats;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  assign req_delay = {dly[3], dly[2], dly[1], dly[0]};

  timer_scheduler #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_delay_i (req_delay),
    .done_o      (done),
    .busy_o      (busy),
    .active_id_o (active_id),
    .count_o     (count)
`ifdef TIMER_SCHED_STATS_EN
    ,
    .stats_o     (stats)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int unsigned id);
    return 4'b0001 << id;
  endfunction

  // Advance to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current (idle) cycle and follow it to its done cycle.
  task automatic do_req(input int unsigned id, input logic [31:0] d);
    req_valid[id] = 1'b1;
    dly[id]       = d;
    #1;
    chk("ready_accept", {28'd0, req_ready}, {28'd0, oh(id)});
    for (int unsigned c = 1; c <= 3 + d; c++) begin
      next_cycle();
      if (c == 1) req_valid[id] = 1'b0;
      #1;
      chk("ready_while_busy", {28'd0, req_ready}, 32'd0);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("count", count, (c >= 2 && c <= 2 + d) ? c - 2 : 32'd0);
      chk("done", {28'd0, done}, (c == 3 + d) ? {28'd0, oh(id)} : 32'd0);
    end
    chk("active_id", {30'd0, active_id}, id);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) dly[i] = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_ready",  {28'd0, req_ready}, 32'd0);
    chk("rst_done",   {28'd0, done},      32'd0);
    chk("rst_count",  count,              32'd0);
    chk("rst_active", {30'd0, active_id}, 32'd0);
    rst_n = 1'b1;

    // Single request D=5 on requester 1: done in cycle 8.
    next_cycle();
    do_req(1, 32'd5);
    next_cycle();
    #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);

    // D=0 then immediate back-to-back D=2.
    do_req(0, 32'd0);
    next_cycle();
    #1;
    chk("count_zero_b2b", count, 32'd0);
    do_req(0, 32'd2);

    // Round-robin with all requesters valid, D=1.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) dly[i] = 32'd1;
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", {28'd0, req_ready}, {28'd0, oh(exp_order[k])});
      for (int unsigned c = 1; c <= 4; c++) begin
        next_cycle();
        #1;
        chk("rr_ready_busy", {28'd0, req_ready}, 32'd0);
        chk("rr_done", {28'd0, done}, (c == 4) ? {28'd0, oh(exp_order[k])} : 32'd0);
      end
      chk("rr_active", {30'd0, active_id}, exp_order[k]);
      next_cycle();
    end
    req_valid = '0;

    // Requester 2 arrives during requester 0's RUN (D=10).
    next_cycle();
    req_valid[0] = 1'b1;
    dly[0]       = 32'd10;
    #1;
    chk("ovl_accept0", {28'd0, req_ready}, 32'h1);
    next_cycle();
    req_valid[0] = 1'b0;
    for (int unsigned c = 2; c <= 13; c++) begin
      next_cycle();
      if (c == 2) begin
        req_valid[2] = 1'b1;
        dly[2]       = 32'd3;
      end
      #1;
      chk("ovl_ready_held", {28'd0, req_ready}, 32'd0);
      chk("ovl_done0", {28'd0, done}, (c == 13) ? 32'h1 : 32'd0);
    end
    next_cycle();
    #1;
    chk("ovl_accept2", {28'd0, req_ready}, 32'h4);
    for (int unsigned c = 15; c <= 20; c++) begin
      next_cycle();
      if (c == 15) req_valid[2] = 1'b0;
      #1;
      chk("ovl_done2", {28'd0, done}, (c == 20) ? 32'h4 : 32'd0);
    end

    // Reset asserted mid-RUN at count 7.
    next_cycle();
    req_valid[3] = 1'b1;
    dly[3]       = 32'd20;
    #1;
    chk("mrst_accept", {28'd0, req_ready}, 32'h8);
    for (int unsigned c = 1; c <= 9; c++) begin
      next_cycle();
      if (c == 1) req_valid[3] = 1'b0;
    end
    #1;
    chk("mrst_count7", count, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {28'd0, done}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 25; c++) begin
      next_cycle();
      #1;
      chk("mrst_no_done", {28'd0, done}, 32'd0);
      chk("mrst_idle", {31'd0, busy}, 32'd0);
    end
    do_req(1, 32'd3);

`ifdef TIMER_SCHED_STATS_EN
    for (int unsigned k = 0; k < 3; k++) begin
      next_cycle();
      do_req(3, 32'd0);
    end
    next_cycle();
    #1;
    chk("stats3", {16'd0, stats[63:48]}, 32'd3);
    chk("stats1", {16'd0, stats[31:16]}, 32'd1);
    chk("stats0", {16'd0, stats[15:0]},  32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
